opb_register_bank_ppc2simulink: RTL and testbench

- Successor to the single-word PPC-to-fabric software register: a bank of C_NUM_REGS 32-bit OPB-writable registers.
- Adds byte-enable writes, software readback and an optional atomic commit mode (shadow → active on one control write).
- Adds a user update strobe and a commit counter.
- Sits on the OPB bus in the XPS base system; drives fabric gain/config words, such as the per-channel quantiser gains.

---
 rtl/opb_reg_pkg.sv | 35 +++
 rtl/opb_slave_ack_decode.sv | 45 ++++
 rtl/opb_register_bank_ppc2simulink.sv | 154 +++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB register bank: bus width, control-word
// layout, byte-enable merge and window word-offset helpers.
package opb_reg_pkg;

   localparam int OPB_DWIDTH      = 32;
   localparam int CTRL_COMMIT_BIT = 0;
   localparam int OFFSET_W        = 30;

   // Layout of the word returned when reading the control offset.
   typedef struct packed {
      logic [15:0] commit_count;
      logic [7:0]  num_regs;
      logic [6:0]  reserved;
      logic        commit_mode;
   } ctrl_word_t;

   // be[3] is OPB BE[0] and selects the most significant byte.
   function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return res;
   endfunction

   function automatic logic [OFFSET_W-1:0] word_offset(input logic [31:0] addr,
                                                       input logic [31:0] base);
      logic [31:0] diff;
      diff = addr - base;
      return diff[31:2];
   endfunction

endpackage

// File: rtl/opb_slave_ack_decode.sv
// OPB slave front end: address window decode, word offset, one-cycle
// transfer acknowledge with retrigger guard, and registered read-data gating.
module opb_slave_ack_decode
   import opb_reg_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h0108F900,
   parameter logic [31:0] C_HIGHADDR = 32'h0108F9FF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                select,
   input  logic [31:0]         abus,
   input  logic                rnw,
   input  logic [31:0]         rdata,
   output logic                hit,
   output logic [OFFSET_W-1:0] word_off,
   output logic                xfer_ack,
   output logic [31:0]         dbus
);

   logic        ack_q;
   logic [31:0] dbus_q;
   logic        in_window;

   assign in_window = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
   // The ack cycle itself never starts a new transfer.
   assign hit       = select && in_window && !ack_q;
   assign word_off  = word_offset(abus, C_BASEADDR);

   // Ack and read data are registered so they appear exactly one cycle after the hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q  <= 1'b0;
         dbus_q <= '0;
      end else begin
         ack_q  <= hit;
         dbus_q <= (hit && rnw) ? rdata : '0;
      end
   end

   // A reset arriving in the ack cycle kills the ack; the master then times out.
   assign xfer_ack = ack_q & ~rst;
   assign dbus     = rst ? '0 : dbus_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of OPB-writable 32-bit words driving fabric configuration, with
// byte-enable writes, readback and optional shadow/commit update.
module opb_register_bank_ppc2simulink
   import opb_reg_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR    = 32'h0108F900,
   parameter logic [31:0] C_HIGHADDR    = 32'h0108F9FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter int          C_NUM_REGS    = 4,
   parameter int          C_COMMIT_MODE = 1,
   parameter logic [31:0] C_RESET_VALUE = 32'h00000000,
   parameter string       C_FAMILY      = "virtex5"
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst,
   output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
   output logic                      Sl_errAck,
   output logic                      Sl_retry,
   output logic                      Sl_toutSup,
   output logic                      Sl_xferAck,
   input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
   input  logic [0:3]                OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
   input  logic                      OPB_RNW,
   input  logic                      OPB_select,
   input  logic                      OPB_seqAddr,
   output logic [32*C_NUM_REGS-1:0]  user_data_out,
   output logic                      user_update,
   output logic [15:0]               commit_count
);

   localparam int N     = C_NUM_REGS;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   if (C_OPB_DWIDTH != OPB_DWIDTH) begin : g_bad_dwidth
      $error("only a 32-bit OPB data bus is supported");
   end
   if (C_OPB_AWIDTH != 32) begin : g_bad_awidth
      $error("only a 32-bit OPB address bus is supported");
   end
   if (N < 1 || N > 64) begin : g_bad_nregs
      $error("C_NUM_REGS must be 1..64");
   end
   if (C_FAMILY == "") begin : g_bad_family
      $error("C_FAMILY must name a target family");
   end

   // Bus vectors are big-endian numbered; index 0 is the value MSB.
   logic [31:0]         abus;
   logic [31:0]         wdata;
   logic [3:0]          be;
   logic [31:0]         rdata;
   logic [31:0]         dbus;
   logic                hit;
   logic [OFFSET_W-1:0] word_off;
   logic [IDX_W-1:0]    idx;
   logic                is_data;
   logic                is_ctrl;
   logic                wr;
   logic                commit;
   ctrl_word_t          ctrl;

   logic [31:0] shadow_q [N];
   logic [31:0] active_q [N];
   logic [15:0] commit_cnt_q;
   logic        update_q;

   assign abus  = OPB_ABus;
   assign wdata = OPB_DBus;
   assign be    = OPB_BE;

   opb_slave_ack_decode #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR)
   ) u_ack_decode (
      .clk      (OPB_Clk),
      .rst      (OPB_Rst),
      .select   (OPB_select),
      .abus     (abus),
      .rnw      (OPB_RNW),
      .rdata    (rdata),
      .hit      (hit),
      .word_off (word_off),
      .xfer_ack (Sl_xferAck),
      .dbus     (dbus)
   );

   assign idx     = word_off[IDX_W-1:0];
   assign is_data = word_off < OFFSET_W'(N);
   assign is_ctrl = word_off == OFFSET_W'(N);
   assign wr      = hit & ~OPB_RNW;
   // Commit needs the low byte enabled, since that byte carries the commit bit.
   assign commit  = wr & is_ctrl & be[0] & wdata[CTRL_COMMIT_BIT];

   // Read mux: shadow words, then the status/control word, else zero.
   always_comb begin
      ctrl.commit_count = commit_cnt_q;
      ctrl.num_regs     = 8'(N);
      ctrl.reserved     = '0;
      ctrl.commit_mode  = (C_COMMIT_MODE != 0);
      rdata             = '0;
      if (is_data) begin
         rdata = shadow_q[idx];
      end else if (is_ctrl) begin
         rdata = ctrl;
      end
   end

   // Shadow writes, active-word update (immediate or on commit) and commit counting.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         for (int i = 0; i < N; i++) begin
            shadow_q[i] <= C_RESET_VALUE;
            active_q[i] <= C_RESET_VALUE;
         end
         commit_cnt_q <= '0;
         update_q     <= 1'b0;
      end else begin
         update_q <= 1'b0;
         if (wr && is_data) begin
            shadow_q[idx] <= be_merge(shadow_q[idx], wdata, be);
            if (C_COMMIT_MODE == 0) begin
               active_q[idx] <= be_merge(shadow_q[idx], wdata, be);
               update_q      <= 1'b1;
            end
         end
         if (commit) begin
            commit_cnt_q <= commit_cnt_q + 16'd1;
            if (C_COMMIT_MODE != 0) begin
               for (int i = 0; i < N; i++) begin
                  active_q[i] <= shadow_q[i];
               end
               update_q <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_out
      assign user_data_out[32*g +: 32] = active_q[g];
   end

   assign user_update  = update_q & ~OPB_Rst;
   assign commit_count = commit_cnt_q;
   assign Sl_DBus      = dbus;
   assign Sl_errAck    = 1'b0;
   assign Sl_retry     = 1'b0;
   assign Sl_toutSup   = 1'b0;

   logic unused_ok;
   assign unused_ok = OPB_seqAddr;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: a commit-mode instance and an
// immediate-mode instance share one bus; both are checked against a
// word-array model of the register map.
module tb_opb_register_bank_ppc2simulink;

   localparam logic [31:0] BASE = 32'h0108F900;
   localparam logic [31:0] HIGH = 32'h0108F9FF;
   localparam int          NREG = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:31] opb_abus;
   logic [0:3]  opb_be;
   logic [0:31] opb_dbus;
   logic        opb_rnw;
   logic        opb_sel;
   logic        opb_seq;

   logic [0:31]  dbus1, dbus0;
   logic         err1, err0, retry1, retry0, tout1, tout0, ack1, ack0;
   logic [127:0] udo1, udo0;
   logic         upd1, upd0;
   logic [15:0]  cc1, cc0;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_shadow [NREG];
   logic [31:0] m_act1   [NREG];
   logic [31:0] m_act0   [NREG];
   int          m_cc;

   always #5 clk = ~clk;

   opb_register_bank_ppc2simulink #(.C_COMMIT_MODE(1)) dut1 (
      .OPB_Clk(clk), .OPB_Rst(rst), .Sl_DBus(dbus1), .Sl_errAck(err1),
      .Sl_retry(retry1), .Sl_toutSup(tout1), .Sl_xferAck(ack1),
      .OPB_ABus(opb_abus), .OPB_BE(opb_be), .OPB_DBus(opb_dbus),
      .OPB_RNW(opb_rnw), .OPB_select(opb_sel), .OPB_seqAddr(opb_seq),
      .user_data_out(udo1), .user_update(upd1), .commit_count(cc1));

   opb_register_bank_ppc2simulink #(.C_COMMIT_MODE(0)) dut0 (
      .OPB_Clk(clk), .OPB_Rst(rst), .Sl_DBus(dbus0), .Sl_errAck(err0),
      .Sl_retry(retry0), .Sl_toutSup(tout0), .Sl_xferAck(ack0),
      .OPB_ABus(opb_abus), .OPB_BE(opb_be), .OPB_DBus(opb_dbus),
      .OPB_RNW(opb_rnw), .OPB_select(opb_sel), .OPB_seqAddr(opb_seq),
      .user_data_out(udo0), .user_update(upd0), .commit_count(cc0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ctrl_word(input int mode);
      return 32'(m_cc * 65536 + NREG * 256 + mode);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_shadow[i] = 32'h0;
         m_act1[i]   = 32'h0;
         m_act0[i]   = 32'h0;
      end
      m_cc = 0;
   endtask

   task automatic chk_outputs(input string tag, input bit eu1, input bit eu0);
      for (int i = 0; i < NREG; i++) begin
         chk({tag, "_udo1"}, udo1[32*i +: 32], m_act1[i]);
         chk({tag, "_udo0"}, udo0[32*i +: 32], m_act0[i]);
      end
      chk({tag, "_upd1"}, 32'(upd1), 32'(eu1));
      chk({tag, "_upd0"}, 32'(upd0), 32'(eu0));
      chk({tag, "_cc1"}, 32'(cc1), 32'(m_cc));
      chk({tag, "_cc0"}, 32'(cc0), 32'(m_cc));
   endtask

   // One complete bus transfer: select for one cycle, check ack/data/outputs
   // in the following cycle and quiet bus in the one after.
   task automatic xfer(input logic [31:0] addr, input bit is_rd, input logic [0:3] be_i,
                       input logic [31:0] data, output logic [31:0] rd);
      bit          in_win;
      int          off;
      logic [31:0] exp1, exp0, d1, d0;
      bit          eu1, eu0;
      in_win = (addr >= BASE) && (addr <= HIGH);
      off    = int'((addr - BASE) >> 2);
      exp1 = 32'h0; exp0 = 32'h0; eu1 = 1'b0; eu0 = 1'b0;
      if (in_win) begin
         if (is_rd) begin
            if (off < NREG) begin
               exp1 = m_shadow[off];
               exp0 = m_shadow[off];
            end else if (off == NREG) begin
               exp1 = ctrl_word(1);
               exp0 = ctrl_word(0);
            end
         end else if (off < NREG) begin
            for (int k = 0; k < 4; k++)
               if (be_i[k]) m_shadow[off][31-8*k -: 8] = data[31-8*k -: 8];
            m_act0[off] = m_shadow[off];
            eu0 = 1'b1;
         end else if (off == NREG && be_i[3] && data[0]) begin
            m_cc = (m_cc + 1) % 65536;
            for (int i = 0; i < NREG; i++) m_act1[i] = m_shadow[i];
            eu1 = 1'b1;
         end
      end
      @(negedge clk);
      opb_abus = addr; opb_rnw = is_rd; opb_be = be_i; opb_dbus = data; opb_sel = 1'b1;
      #1;
      chk("ack_same_cycle", 32'(ack1), 32'h0);
      @(negedge clk);
      opb_sel = 1'b0;
      d1 = dbus1; d0 = dbus0;
      chk("ack1", 32'(ack1), 32'(in_win));
      chk("ack0", 32'(ack0), 32'(in_win));
      chk("rdata1", d1, exp1);
      chk("rdata0", d0, exp0);
      chk_outputs("post", eu1, eu0);
      rd = d1;
      @(negedge clk);
      chk("ack_drop", 32'(ack1), 32'h0);
      chk("dbus_drop", d1 & 32'(dbus1), 32'h0);
      chk("upd1_drop", 32'(upd1), 32'h0);
      chk("upd0_drop", 32'(upd0), 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      int          acks;
      rst = 1'b1; opb_abus = '0; opb_be = '0; opb_dbus = '0;
      opb_rnw = 1'b0; opb_sel = 1'b0; opb_seq = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack1), 32'h0);
      chk("rst_dbus", dbus1, 32'h0);
      chk_outputs("rst", 1'b0, 1'b0);
      chk("tied", {29'h0, err1 | err0, retry1 | retry0, tout1 | tout0}, 32'h0);
      rst = 1'b0;

      // reset readback of a data word and the control word
      xfer(BASE + 32'h0, 1'b1, 4'b1111, 32'h0, rd);
      chk("rd_off0", rd, 32'h00000000);
      xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'h0, rd);
      chk("rd_ctrl", rd, 32'h00000401);

      // shadow write does not reach commit-mode outputs
      xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'hDEADBEEF, rd);
      xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0, rd);
      chk("rd_word1", rd, 32'hDEADBEEF);
      chk("udo1_w1_uncommitted", udo1[63:32], 32'h0);

      // commit, then a non-committing control write
      xfer(BASE + 32'h10, 1'b0, 4'b1111, 32'h00000001, rd);
      chk("udo1_w1_committed", udo1[63:32], 32'hDEADBEEF);
      chk("cc_after_commit", 32'(cc1), 32'h1);
      xfer(BASE + 32'h10, 1'b0, 4'b1111, 32'h00000000, rd);
      chk("cc_no_commit", 32'(cc1), 32'h1);
      xfer(BASE + 32'h10, 1'b0, 4'b1110, 32'h00000001, rd);
      chk("cc_be3_clear", 32'(cc1), 32'h1);

      // byte-enable merge
      xfer(BASE + 32'h0, 1'b0, 4'b1111, 32'h11223344, rd);
      xfer(BASE + 32'h0, 1'b0, 4'b0101, 32'hAABBCCDD, rd);
      xfer(BASE + 32'h0, 1'b1, 4'b1111, 32'h0, rd);
      chk("be_merge", rd, 32'h11BB33DD);

      // immediate mode: data write visible next cycle, BE=0000 still pulses
      xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'h00000005, rd);
      chk("udo0_w2", udo0[95:64], 32'h5);
      xfer(BASE + 32'hC, 1'b0, 4'b0000, 32'hFFFFFFFF, rd);

      // window edges
      xfer(BASE + 32'hFC, 1'b1, 4'b1111, 32'h0, rd);
      chk("rd_top", rd, 32'h0);
      xfer(BASE + 32'h20, 1'b0, 4'b1111, 32'h12345678, rd);
      @(negedge clk);
      opb_abus = 32'h0108FA00; opb_rnw = 1'b1; opb_sel = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("outside_ack", 32'(ack1), 32'h0);
         chk("outside_dbus", dbus1, 32'h0);
      end
      opb_sel = 1'b0;
      xfer(BASE - 32'h4, 1'b1, 4'b1111, 32'h0, rd);

      // select held for three cycles: one ack while held, next one after t+2 hit
      @(negedge clk);
      opb_abus = BASE; opb_rnw = 1'b1; opb_sel = 1'b1;
      acks = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         acks += int'(ack1);
         @(negedge clk);
      end
      opb_sel = 1'b0;
      chk("held_select_acks", 32'(acks), 32'h1);
      chk("held_second_ack", 32'(ack1), 32'h1);
      @(negedge clk);
      chk("held_ack_drop", 32'(ack1), 32'h0);

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         int          o;
         o = int'($urandom_range(0, 7));
         a = (o == 7) ? BASE + 32'h100 + 4 * $urandom_range(0, 3) : BASE + 32'(o * 4);
         xfer(a, bit'($urandom_range(0, 1)), 4'($urandom), $urandom, rd);
      end

      // commit counter wrap
      @(negedge clk);
      force dut1.commit_cnt_q = 16'hFFFE;
      force dut0.commit_cnt_q = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut1.commit_cnt_q;
      release dut0.commit_cnt_q;
      m_cc = 32'hFFFE;
      @(negedge clk);
      chk("cc_preset", 32'(cc1), 32'hFFFE);
      xfer(BASE + 32'h10, 1'b0, 4'b0001, 32'h00000001, rd);
      xfer(BASE + 32'h10, 1'b0, 4'b1111, 32'h80000001, rd);
      chk("cc_wrap", 32'(cc1), 32'h0);

      // reset in the ack cycle
      @(negedge clk);
      opb_abus = BASE; opb_rnw = 1'b0; opb_be = 4'b1111; opb_dbus = 32'hCAFEF00D; opb_sel = 1'b1;
      @(negedge clk);
      opb_sel = 1'b0; rst = 1'b1;
      #1;
      chk("rst_ack_cycle_ack1", 32'(ack1), 32'h0);
      chk("rst_ack_cycle_ack0", 32'(ack0), 32'h0);
      chk("rst_ack_cycle_upd0", 32'(upd0), 32'h0);
      @(negedge clk);
      model_reset();
      chk("rst_after_ack", 32'(ack1), 32'h0);
      chk("rst_after_dbus", dbus1, 32'h0);
      chk_outputs("rst_after", 1'b0, 1'b0);
      rst = 1'b0;
      xfer(BASE, 1'b1, 4'b1111, 32'h0, rd);
      chk("rd_after_rst", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
